ula_mdu: RTL and testbench

ULA_MDU -- requirements
Module: ula_mdu

---
 rtl/ula_mdu_pkg.sv | 17 +
 rtl/mdu_step.sv | 58 +++++
 rtl/ula_mdu.sv | 183 ++++++++++++++++++
 tb/tb_ula_mdu.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ula_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: HI/LO op codes and FSM states.
package ula_mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// Combinational datapath of the MDU: operand magnitude conversion and one radix-2
// iteration (LSB-first shift-add multiply or restoring shift-subtract divide).
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] mag1_o,
  output logic [WIDTH-1:0] mag2_o,
  output logic             neg1_o,
  output logic             neg2_o,
  input  logic             div_i,
  input  logic [WIDTH:0]   acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH:0]   acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] add_sel;
  logic [WIDTH:0] sub_shifted;
  logic [WIDTH:0] sub_diff;

  always_comb begin
    neg1_o = signed_i & in1_i[WIDTH-1];
    neg2_o = signed_i & in2_i[WIDTH-1];
    mag1_o = neg1_o ? -in1_i : in1_i;
    mag2_o = neg2_o ? -in2_i : in2_i;
  end

  // Multiply: acc_lo holds the remaining multiplier bits, acc_hi the partial product.
  assign add_sum = acc_hi_i + {1'b0, opb_i};
  assign add_sel = acc_lo_i[0] ? add_sum : acc_hi_i;

  // Divide: acc_lo shifts the dividend out and the quotient in; acc_hi is the remainder.
  assign sub_shifted = {acc_hi_i[WIDTH-1:0], acc_lo_i[WIDTH-1]};
  assign sub_diff    = sub_shifted - {1'b0, opb_i};

  always_comb begin
    acc_hi_o = acc_hi_i;
    acc_lo_o = acc_lo_i;
    if (div_i) begin
      if (!sub_diff[WIDTH]) begin
        acc_hi_o = sub_diff;
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_o = sub_shifted;
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_hi_o = {1'b0, add_sel[WIDTH:1]};
      acc_lo_o = {add_sel[0], acc_lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ula_mdu.sv
// Multi-cycle MIPS-style multiply/divide unit with architectural HI/LO registers.
// Iterative ops take one accept cycle, WIDTH CALC cycles and one FIX cycle.
module ula_mdu
  import ula_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Div_Zero_Flag
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             flag_q, flag_d;

  logic             is_signed;
  logic [WIDTH-1:0] mag1, mag2;
  logic             neg1, neg2;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign is_signed = (OP == MDU_MULT) || (OP == MDU_DIV);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .in1_i    (In1),
    .in2_i    (In2),
    .signed_i (is_signed),
    .mag1_o   (mag1),
    .mag2_o   (mag2),
    .neg1_o   (neg1),
    .neg2_o   (neg2),
    .div_i    (div_q),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .opb_i    (opb_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  // Sign correction applied in FIX; remainder follows the dividend's sign.
  assign prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = rneg_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    in1_d    = in1_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    flag_d   = flag_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (OP)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              state_d  = CALC;
              cnt_d    = '0;
              div_d    = OP[1];
              neg_d    = neg1 ^ neg2;
              rneg_d   = neg1;
              dz_d     = (In2 == '0);
              in1_d    = In1;
              acc_hi_d = '0;
              // Divide shifts the dividend through acc_lo; multiply shifts the multiplier.
              acc_lo_d = OP[1] ? mag1 : mag2;
              opb_d    = OP[1] ? mag2 : mag1;
            end
            MDU_MTHI: begin
              hi_d   = In1;
              done_d = 1'b1;
              flag_d = 1'b0;
            end
            MDU_MTLO: begin
              lo_d   = In1;
              done_d = 1'b1;
              flag_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        flag_d  = div_q & dz_q;
        if (!div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = in1_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      in1_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      in1_q    <= in1_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      flag_q   <= flag_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign HI            = hi_q;
  assign LO            = lo_q;
  assign Div_Zero_Flag = flag_q;

endmodule

// File: tb/tb_ula_mdu.sv
// Directed self-checking bench for ula_mdu with hand-computed HI/LO results.
module tb_ula_mdu;
  import ula_mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   OP = 3'd0;
  logic [W-1:0] In1 = '0;
  logic [W-1:0] In2 = '0;
  logic         busy, done, Div_Zero_Flag;
  logic [W-1:0] HI, LO;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  ula_mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .OP            (OP),
    .In1           (In1),
    .In2           (In2),
    .busy          (busy),
    .done          (done),
    .HI            (HI),
    .LO            (LO),
    .Div_Zero_Flag (Div_Zero_Flag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; OP = op; In1 = a; In2 = b;
    @(posedge clk); #1;
    start = 1'b0; OP = 3'd7; In1 = $urandom; In2 = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Called right after the accepting edge of an iterative op.
  task automatic finish_op(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el, input logic ef);
    int n;
    check({tag, "_busy_on"}, busy, 1);
    wait_done(n);
    check({tag, "_latency"}, n + 1, W + 2);
    check({tag, "_hi"}, HI, eh);
    check({tag, "_lo"}, LO, el);
    check({tag, "_flag"}, Div_Zero_Flag, ef);
    check({tag, "_busy_off"}, busy, 0);
    $display("%s: HI=%h LO=%h flag=%b edges=%0d", tag, HI, LO, Div_Zero_Flag, n + 1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ef);
    issue(op, a, b);
    finish_op(tag, eh, el, ef);
  endtask

  initial begin
    int base;
    int n;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_flag", Div_Zero_Flag, 0);
    $display("reset: busy=%b done=%b HI=%h LO=%h", busy, done, HI, LO);
    @(negedge clk); rst_n = 1'b1;

    run_op("mult_m2x3",   MDU_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_op("multu_max",   MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("div_m7d2",    MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu_7d0",    MDU_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1);
    run_op("div_ovf",     MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("div_100dm7",  MDU_DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0);
    run_op("div_9d0",     MDU_DIV,   32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF, 1'b1);

    // Reset in the middle of a divide
    issue(MDU_DIV, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check("midrst_busy", busy, 0);
    check("midrst_hi", HI, 0);
    check("midrst_lo", LO, 0);
    check("midrst_flag", Div_Zero_Flag, 0);
    base = done_cnt;
    $display("midrst: busy=%b HI=%h LO=%h flag=%b", busy, HI, LO, Div_Zero_Flag);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; OP = MDU_MULT; In1 = 32'd7; In2 = 32'hFFFFFFFD;
    @(posedge clk); #1;
    start = 1'b0; In1 = $urandom; In2 = $urandom;
    finish_op("mult_after_rst", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    @(posedge clk); #1;
    check("midrst_single_done", done_cnt - base, 1);

    // Second start while busy must be ignored
    base = done_cnt;
    issue(MDU_MULTU, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; OP = MDU_DIVU; In1 = 32'd100; In2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("busy_start_hi", HI, 0);
    check("busy_start_lo", LO, 15);
    repeat (40) @(posedge clk);
    #1;
    check("busy_start_done_cnt", done_cnt - base, 1);
    check("busy_start_lo_after", LO, 15);
    check("busy_start_idle", busy, 0);
    $display("busy_start: HI=%h LO=%h dones=%0d", HI, LO, done_cnt - base);

    issue(MDU_MTHI, 32'h00001234, 32'h0);
    check("mthi_hi", HI, 32'h1234);
    check("mthi_lo", LO, 15);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 1);
    @(posedge clk); #1;
    check("mthi_done_pulse", done, 0);
    $display("mthi: HI=%h LO=%h", HI, LO);

    issue(MDU_MTLO, 32'h0000ABCD, 32'h0);
    check("mtlo_lo", LO, 32'hABCD);
    check("mtlo_hi", HI, 32'h1234);
    check("mtlo_done", done, 1);
    $display("mtlo: HI=%h LO=%h", HI, LO);

    @(posedge clk); #1;
    base = done_cnt;
    issue(3'd6, 32'hDEADBEEF, 32'h1);
    check("undef_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("undef_no_done", done_cnt - base, 0);
    check("undef_hi", HI, 32'h1234);
    check("undef_lo", LO, 32'hABCD);
    $display("undef_op: HI=%h LO=%h busy=%b", HI, LO, busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
